// File: rtl/lsu_seq_if.sv
// lsu_seq_if: request, memory-piece and response signals of the load/store sequencer.
// master = execute/memory side (requester), slave = the sequencer itself.
interface lsu_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        input  req_ready, mem_en, mem_we, mem_addr, mem_funct3, mem_din, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        output req_ready, mem_en, mem_we, mem_addr, mem_funct3, mem_din, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer splitting misaligned accesses into aligned pieces.
// Defining LSU_MISALIGN_TRAP_EN rejects misaligned requests with rsp_err instead of splitting.
module lsu_seq #(
    parameter int RD_LAT = 1
) (
    input logic      clk,
    input logic      rst_n,
    lsu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    state_e      state_q, state_d;
    logic        we_q, err_q, cnt_q;
    logic [1:0]  piece_q;
    logic [2:0]  f3_q, mf3_q;
    logic [31:0] addr_q, wdata_q, w0_q, w1_q, maddr_q, mdin_q;
    logic [2:0]  size, n_pieces, p_f3;
    logic        mis, last, cnt_done, legal_in, err_in;
    logic [7:0]  p_byte;
    logic [31:0] p_addr, p_din, sh, ext;

    always_comb begin
        size     = f3_q[1:0] == 2'b00 ? 3'd1 : f3_q[1:0] == 2'b01 ? 3'd2 : 3'd4;
        mis      = (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
        n_pieces = we_q ? (mis ? size : 3'd1) : ({1'b0, addr_q[1:0]} + size > 3'd4 ? 3'd2 : 3'd1);
        last     = {1'b0, piece_q} + 3'd1 == n_pieces;
        cnt_done = cnt_q == 1'(RD_LAT - 1);
        // Loads always fetch whole words; misaligned stores degrade to byte stores.
        p_byte   = wdata_q[{piece_q, 3'b000} +: 8];
        p_addr   = !we_q ? {addr_q[31:2], 2'b00} + {28'd0, piece_q, 2'b00} : mis ? addr_q + {30'd0, piece_q} : addr_q;
        p_f3     = !we_q ? 3'b010 : mis ? 3'b000 : f3_q;
        p_din    = !we_q ? mdin_q : mis ? {4{p_byte}} :
                   f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
        sh       = 32'({w1_q, w0_q} >> {addr_q[1:0], 3'b000});
        ext      = f3_q[1:0] == 2'b00 ? {{24{sh[7] & ~f3_q[2]}}, sh[7:0]} :
                   f3_q[1:0] == 2'b01 ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} : sh;
        legal_in = bus.req_we ? bus.req_funct3 <= 3'b010 : !(bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        err_in   = !legal_in || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
        err_in   = !legal_in;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = err_in ? RESP : ISSUE;
            ISSUE:   state_d = !we_q ? WAIT : last ? RESP : ISSUE;
            WAIT:    if (cnt_done) state_d = last ? RESP : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 1'b0;
            piece_q <= 2'd0;
            f3_q    <= 3'd0;
            mf3_q   <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            w0_q    <= 32'd0;
            w1_q    <= 32'd0;
            maddr_q <= 32'd0;
            mdin_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= err_in;
                piece_q <= 2'd0;
            end
            if (state_q == ISSUE) begin
                maddr_q <= p_addr;
                mf3_q   <= p_f3;
                mdin_q  <= p_din;
                cnt_q   <= 1'b0;
                if (we_q) piece_q <= piece_q + 2'd1;
            end
            if (state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_done) begin
                    if (piece_q == 2'd0) w0_q <= bus.mem_dout;
                    else w1_q <= bus.mem_dout;
                    piece_q <= piece_q + 2'd1;
                end
            end
        end
    end

    assign bus.req_ready  = state_q == IDLE;
    assign bus.mem_en     = state_q == ISSUE;
    assign bus.mem_we     = state_q == ISSUE && we_q;
    assign bus.mem_addr   = state_q == ISSUE ? p_addr : maddr_q;
    assign bus.mem_funct3 = state_q == ISSUE ? p_f3 : mf3_q;
    assign bus.mem_din    = state_q == ISSUE ? p_din : mdin_q;
    assign bus.rsp_valid  = state_q == RESP;
    assign bus.rsp_rdata  = state_q == RESP && !we_q && !err_q ? ext : 32'd0;
    assign bus.rsp_err    = state_q == RESP && err_q;
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed vector table plus random requests against a byte-level memory/reference model.
// Two DUTs (RD_LAT=1 and RD_LAT=2) share stimulus; sel picks which one gets requests.
module tb_lsu_seq;
    localparam bit TRAP = `ifdef LSU_MISALIGN_TRAP_EN 1'b1 `else 1'b0 `endif;

    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [2:0] req_f3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [31:0] da1, db1, db2;
    logic o_ready, o_en, o_we, o_rv, o_err;
    logic [2:0] o_f3;
    logic [31:0] o_addr, o_din, o_rd;
    int nchk = 0, nerr = 0;

    always #5 clk = ~clk;

    lsu_seq_if ia ();
    lsu_seq_if ib ();
    lsu_seq #(.RD_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    lsu_seq #(.RD_LAT(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    assign ia.req_valid = req_valid & ~sel;
    assign ib.req_valid = req_valid & sel;
    assign ia.req_we = req_we;
    assign ib.req_we = req_we;
    assign ia.req_funct3 = req_f3;
    assign ib.req_funct3 = req_f3;
    assign ia.req_addr = req_addr;
    assign ib.req_addr = req_addr;
    assign ia.req_wdata = req_wdata;
    assign ib.req_wdata = req_wdata;
    assign ia.mem_dout = da1;
    assign ib.mem_dout = db2;
    assign o_ready = sel ? ib.req_ready : ia.req_ready;
    assign o_en = sel ? ib.mem_en : ia.mem_en;
    assign o_we = sel ? ib.mem_we : ia.mem_we;
    assign o_f3 = sel ? ib.mem_funct3 : ia.mem_funct3;
    assign o_addr = sel ? ib.mem_addr : ia.mem_addr;
    assign o_din = sel ? ib.mem_din : ia.mem_din;
    assign o_rv = sel ? ib.rsp_valid : ia.rsp_valid;
    assign o_rd = sel ? ib.rsp_rdata : ia.rsp_rdata;
    assign o_err = sel ? ib.rsp_err : ia.rsp_err;

    // Byte-addressed memory; untouched bytes read as a fixed address hash.
    logic [7:0] bmem [logic [31:0]];
    function automatic logic [7:0] rd_byte(logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : (a[7:0] ^ a[15:8] ^ 8'hA5);
    endfunction
    function automatic logic [31:0] rd_word(logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rd_byte({a[31:2], 2'b00} + 32'(i));
        return w;
    endfunction
    task automatic wr_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bmem[a + 32'(i)] = w[8*i +: 8];
    endtask
    task automatic mem_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int n;
        logic [31:0] b;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) begin
            b = (a & ~32'(n - 1)) + 32'(i);
            bmem[b] = d[{b[1:0], 3'b000} +: 8];
        end
    endtask

    always @(posedge clk) begin
        if (ia.mem_en && ia.mem_we) mem_store(ia.mem_addr, ia.mem_funct3, ia.mem_din);
        if (ib.mem_en && ib.mem_we) mem_store(ib.mem_addr, ib.mem_funct3, ib.mem_din);
        da1 <= (ia.mem_en && !ia.mem_we) ? rd_word(ia.mem_addr) : $urandom;
        db1 <= (ib.mem_en && !ib.mem_we) ? rd_word(ib.mem_addr) : $urandom;
        db2 <= db1;
    end

    typedef struct packed {logic [31:0] addr; logic [2:0] f3; logic [31:0] din; logic we;} piece_t;
    piece_t pieces[$];
    function automatic piece_t pc(int k);
        return (k < pieces.size()) ? pieces[k] : '0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request: cycle 0 is the accept cycle, cyc is the rsp_valid cycle (-1 on timeout).
    task automatic do_req(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int cyc, output int np);
        int g;
        sel = s;
        rd = 32'd0;
        er = 1'b0;
        cyc = -1;
        pieces.delete();
        @(negedge clk);
        req_we = we;
        req_f3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        g = 0;
        while (!o_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!o_ready) chk("accept_timeout", {63'd0, o_ready}, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (o_en) pieces.push_back('{o_addr, o_f3, o_din, o_we});
            if (o_rv) begin
                cyc = c;
                rd = o_rd;
                er = o_err;
                break;
            end
        end
        np = pieces.size();
    endtask

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] f3);
        int n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 32'(i));
        if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] addr, wdata;
        logic p0v; logic [31:0] p0a, p0w; logic p1v; logic [31:0] p1a, p1w;
        logic [31:0] exp_rd; logic exp_err; int exp_cyc; int exp_np;
    } vec_t;
    vec_t tv[16];

    initial begin
        logic [31:0] rd, exp_rd, got, mask;
        logic er, we, s, mis, legal, exp_err;
        logic [2:0] f3;
        logic [31:0] a, wd;
        int cyc, np, nrsp, n, exp_np, exp_cyc;
        tv[0]  = '{0, 3'b010, 32'h10000004, 0, 1, 32'h10000004, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 3, 1};
        tv[1]  = '{0, 3'b000, 32'h10000003, 0, 1, 32'h10000000, 32'h80FF0000, 0, 0, 0, 32'hFFFFFF80, 0, 3, 1};
        tv[2]  = '{0, 3'b100, 32'h10000003, 0, 0, 0, 0, 0, 0, 0, 32'h00000080, 0, 3, 1};
        tv[3]  = '{0, 3'b010, 32'h10000002, 0, 1, 32'h10000000, 32'h55661234, 1, 32'h10000004, 32'h9ABC7788,
                   TRAP ? 32'h0 : 32'h77885566, TRAP, TRAP ? 1 : 5, TRAP ? 0 : 2};
        tv[4]  = '{1, 3'b010, 32'h10000001, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 32'h0, TRAP, TRAP ? 1 : 5, TRAP ? 0 : 4};
        tv[5]  = '{0, 3'b011, 32'h10000000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0};
        tv[6]  = '{1, 3'b100, 32'h10000000, 32'h12345678, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0};
        tv[7]  = '{0, 3'b001, 32'h10000001, 0, 1, 32'h10000000, 32'h00F0E000, 0, 0, 0,
                   TRAP ? 32'h0 : 32'hFFFFF0E0, TRAP, TRAP ? 1 : 3, TRAP ? 0 : 1};
        tv[8]  = '{0, 3'b010, 32'hFFFFFFFE, 0, 1, 32'hFFFFFFFC, 32'h2211AAAA, 1, 32'h00000000, 32'hBBBB4433,
                   TRAP ? 32'h0 : 32'h44332211, TRAP, TRAP ? 1 : 5, TRAP ? 0 : 2};
        tv[9]  = '{1, 3'b001, 32'h10000012, 32'h1234BEEF, 1, 32'h10000010, 32'h00001111, 0, 0, 0, 32'h0, 0, 2, 1};
        tv[10] = '{0, 3'b010, 32'h10000010, 0, 0, 0, 0, 0, 0, 0, 32'hBEEF1111, 0, 3, 1};
        tv[11] = '{0, 3'b101, 32'h10000012, 0, 0, 0, 0, 0, 0, 0, 32'h0000BEEF, 0, 3, 1};
        tv[12] = '{0, 3'b001, 32'h10000012, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFBEEF, 0, 3, 1};
        tv[13] = '{1, 3'b000, 32'h10000013, 32'h000000A5, 0, 0, 0, 0, 0, 0, 32'h0, 0, 2, 1};
        tv[14] = '{0, 3'b100, 32'h10000013, 0, 0, 0, 0, 0, 0, 0, 32'h000000A5, 0, 3, 1};
        tv[15] = '{0, 3'b000, 32'h10000013, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFA5, 0, 3, 1};

        repeat (3) @(negedge clk);
        chk("rst_flags_a", {59'd0, ia.req_ready, ia.mem_en, ia.mem_we, ia.rsp_valid, ia.rsp_err}, 64'h10);
        chk("rst_flags_b", {59'd0, ib.req_ready, ib.mem_en, ib.mem_we, ib.rsp_valid, ib.rsp_err}, 64'h10);
        chk("rst_addr_a", ia.mem_addr, 0);
        chk("rst_f3_a", ia.mem_funct3, 0);
        chk("rst_din_a", ia.mem_din, 0);
        chk("rst_rdata_a", ia.rsp_rdata, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (tv[i].p0v) wr_word(tv[i].p0a, tv[i].p0w);
            if (tv[i].p1v) wr_word(tv[i].p1a, tv[i].p1w);
            do_req(1'b0, tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, rd, er, cyc, np);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
            chk($sformatf("vec%0d_err", i), er, tv[i].exp_err);
            chk($sformatf("vec%0d_cycle", i), cyc, tv[i].exp_cyc);
            chk($sformatf("vec%0d_pieces", i), np, tv[i].exp_np);
        end

        wr_word(32'h10000004, 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 3'b010, 32'h10000004, 0, rd, er, cyc, np);
        chk("lw_piece_addr", pc(0).addr, 32'h10000004);
        chk("lw_piece_f3", pc(0).f3, 3'b010);
        chk("lw_piece_we", pc(0).we, 0);
        do_req(1'b0, 1'b1, 3'b001, 32'h10000012, 32'h1234BEEF, rd, er, cyc, np);
        chk("sh_piece_din", pc(0).din, 32'hBEEFBEEF);
        chk("sh_piece_f3", pc(0).f3, 3'b001);
        do_req(1'b0, 1'b1, 3'b000, 32'h10000013, 32'h000000A5, rd, er, cyc, np);
        chk("sb_piece_din", pc(0).din, 32'hA5A5A5A5);
        do_req(1'b0, 1'b1, 3'b010, 32'h10000001, 32'hAABBCCDD, rd, er, cyc, np);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("sw_mis_trap_err", er, 1);
        chk("sw_mis_trap_pieces", np, 0);
`else
        for (int k = 0; k < 4; k++) begin
            wd = 32'hAABBCCDD;
            chk($sformatf("sw_mis_addr%0d", k), pc(k).addr, 32'h10000001 + 32'(k));
            chk($sformatf("sw_mis_din%0d", k), pc(k).din, {4{wd[8*k +: 8]}});
            chk($sformatf("sw_mis_f3_%0d", k), {pc(k).we, pc(k).f3}, 4'b1000);
        end
        do_req(1'b0, 1'b0, 3'b010, 32'h10000002, 0, rd, er, cyc, np);
        chk("lw_cross_addr0", pc(0).addr, 32'h10000000);
        chk("lw_cross_addr1", pc(1).addr, 32'h10000004);
        do_req(1'b0, 1'b0, 3'b010, 32'hFFFFFFFE, 0, rd, er, cyc, np);
        chk("lw_wrap_addr0", pc(0).addr, 32'hFFFFFFFC);
        chk("lw_wrap_addr1", pc(1).addr, 32'h00000000);
        do_req(1'b1, 1'b0, 3'b010, 32'h10000002, 0, rd, er, cyc, np);
        chk("lat2_cross_cycle", cyc, 7);
`endif
        wr_word(32'h10000004, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 3'b010, 32'h10000004, 0, rd, er, cyc, np);
        chk("lat2_lw_cycle", cyc, 4);
        chk("lat2_lw_rdata", rd, 32'hDEADBEEF);

        sel = 1'b0;
        @(negedge clk);
        req_we = 1'b0;
        req_f3 = 3'b010;
        req_addr = 32'h10000002;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", ia.req_ready, 1);
        chk("rst_mid_rsp", ia.rsp_valid, 0);
        chk("rst_mid_en", ia.mem_en, 0);
        rst_n = 1'b1;
        nrsp = 0;
        repeat (6) begin
            @(negedge clk);
            nrsp += int'(ia.rsp_valid);
        end
        chk("rst_mid_no_rsp", nrsp, 0);

        for (int t = 0; t < 300; t++) begin
            s = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            case ($urandom_range(0, 2))
                0: a = 32'h10000000 + 32'($urandom_range(0, 31));
                1: a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 15));
            endcase
            n = 1 << f3[1:0];
            legal = we ? f3 <= 3'b010 : !(f3 == 3'b011 || f3 >= 3'b110);
            mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
            exp_err = !legal || (TRAP && mis);
            exp_np = exp_err ? 0 : we ? (mis ? n : 1) : (int'(a[1:0]) + n > 4 ? 2 : 1);
            exp_cyc = exp_err ? 1 : we ? exp_np + 1 : exp_np * (s ? 3 : 2) + 1;
            exp_rd = (exp_err || we) ? 32'd0 : ref_load(a, f3);
            do_req(s, we, f3, a, wd, rd, er, cyc, np);
            chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            chk($sformatf("rnd%0d_err", t), er, exp_err);
            chk($sformatf("rnd%0d_cycle", t), cyc, exp_cyc);
            chk($sformatf("rnd%0d_pieces", t), np, exp_np);
            if (we && !exp_err) begin
                got = 32'd0;
                for (int i = 0; i < n; i++) got[8*i +: 8] = rd_byte(a + 32'(i));
                mask = n == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * n)) - 32'd1;
                chk($sformatf("rnd%0d_stored", t), got, wd & mask);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
